// File: rtl/dsp_frame_sequencer.sv
// ----------------------------------------------------------------------------
// dsp_frame_sequencer
//
// Multi-channel sample sequencer sitting between the audio I/O and dsp_core.
// A frame of N_CHANNELS samples is latched, the core is ticked once per
// channel in ascending order, each result is collected into a private slot,
// and the complete output frame is presented in one cycle.
// Also provides frame bypass, overrun detection/counting, a per-channel
// core-ready watchdog with a FAULT state, and deferral of register-write
// commits to frame boundaries.
//
// Ports
//   clk, reset         : clock, synchronous active-low reset
//   enable             : 1 = process through core, 0 = bypass (sampled in IDLE)
//   in_samples/in_valid: input frame and one-cycle frame strobe
//   ready              : high only while idle; frame accepted on in_valid&ready
//   out_samples/out_valid : output frame and one-cycle strobe
//   core_tick/core_channel/core_sample_in : start pulse, channel, sample to core
//   core_sample_out/core_ready            : result and idle/result-valid from core
//   commit_req/core_commit : commit request in, one-cycle commit pulse out
//   clear_errors       : clears sticky flags, leaves FAULT
//   overrun/timeout    : sticky error flags
//   frame_ctr          : completed frames (wraps)
//   overrun_ctr        : dropped frames (saturates)
//
// Every output is a register; the combinational block computes the value each
// output takes in the state being entered, so e.g. core_tick is high exactly
// during the ISSUE cycle.
// ----------------------------------------------------------------------------
module dsp_frame_sequencer #(
    parameter int DATA_W         = 16,
    parameter int N_CHANNELS     = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CTR_W          = 32,
    localparam int CH_W          = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
    localparam int FRM_W         = N_CHANNELS * DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [FRM_W-1:0]  in_samples,
    input  logic              in_valid,
    output logic              ready,
    output logic [FRM_W-1:0]  out_samples,
    output logic              out_valid,
    output logic              core_tick,
    output logic [CH_W-1:0]   core_channel,
    output logic [DATA_W-1:0] core_sample_in,
    input  logic [DATA_W-1:0] core_sample_out,
    input  logic              core_ready,
    input  logic              commit_req,
    output logic              core_commit,
    input  logic              clear_errors,
    output logic              overrun,
    output logic              timeout,
    output logic [CTR_W-1:0]  frame_ctr,
    output logic [CTR_W-1:0]  overrun_ctr
);

    localparam int               WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CHANNELS - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_DONE,
        S_FAULT
    } state_t;

    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] v);
        return (&v) ? v : v + CTR_W'(1);
    endfunction

    state_t             state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [FRM_W-1:0]   latched_q, latched_d;
    logic [FRM_W-1:0]   slots_q, slots_d;
    logic               commit_pending_q, commit_pending_d;

    logic               ready_d;
    logic [FRM_W-1:0]   out_samples_d;
    logic               out_valid_d;
    logic               core_tick_d;
    logic [CH_W-1:0]    core_channel_d;
    logic [DATA_W-1:0]  core_sample_in_d;
    logic               core_commit_d;
    logic               overrun_d;
    logic               timeout_d;
    logic [CTR_W-1:0]   frame_ctr_d;
    logic [CTR_W-1:0]   overrun_ctr_d;

    always_comb begin
        state_d          = state_q;
        ch_d             = ch_q;
        wd_d             = wd_q;
        latched_d        = latched_q;
        slots_d          = slots_q;
        commit_pending_d = commit_pending_q | commit_req;
        out_samples_d    = out_samples;
        out_valid_d      = 1'b0;
        core_tick_d      = 1'b0;
        core_channel_d   = core_channel;
        core_sample_in_d = core_sample_in;
        core_commit_d    = 1'b0;
        overrun_d        = overrun;
        timeout_d        = timeout;
        frame_ctr_d      = frame_ctr;
        overrun_ctr_d    = overrun_ctr;

        // Clear first so that a same-cycle error event still sets its flag.
        if (clear_errors) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end

        // A strobe outside IDLE (DONE and FAULT included) is dropped.
        if (in_valid && (state_q != S_IDLE)) begin
            overrun_d     = 1'b1;
            overrun_ctr_d = sat_inc(overrun_ctr);
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid && enable) begin
                    // Accepted frame: any commit stays pending until its DONE.
                    latched_d        = in_samples;
                    ch_d             = '0;
                    wd_d             = '0;
                    state_d          = S_ISSUE;
                    core_tick_d      = 1'b1;
                    core_channel_d   = '0;
                    core_sample_in_d = in_samples[DATA_W-1:0];
                end else begin
                    if (in_valid) begin
                        out_samples_d = in_samples;
                        out_valid_d   = 1'b1;
                        frame_ctr_d   = frame_ctr + CTR_W'(1);
                    end
                    if (commit_pending_q || commit_req) begin
                        core_commit_d    = 1'b1;
                        commit_pending_d = 1'b0;
                    end
                end
            end

            S_ISSUE: begin
                wd_d    = wd_q + WD_W'(1);
                state_d = S_GUARD;
            end

            // core_ready may still reflect the previous operation here.
            S_GUARD: begin
                wd_d    = wd_q + WD_W'(1);
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (core_ready) begin
                    slots_d[ch_q*DATA_W +: DATA_W] = core_sample_out;
                    if (ch_q == LAST_CH) begin
                        state_d       = S_DONE;
                        out_valid_d   = 1'b1;
                        out_samples_d = slots_d;
                        frame_ctr_d   = frame_ctr + CTR_W'(1);
                        if (commit_pending_q || commit_req) begin
                            core_commit_d    = 1'b1;
                            commit_pending_d = 1'b0;
                        end
                    end else begin
                        ch_d             = ch_q + CH_W'(1);
                        wd_d             = '0;
                        state_d          = S_ISSUE;
                        core_tick_d      = 1'b1;
                        core_channel_d   = ch_d;
                        core_sample_in_d = latched_q[ch_d*DATA_W +: DATA_W];
                    end
                end else begin
                    // wd_q counts cycles since the tick; the last allowed
                    // waiting cycle is TIMEOUT_CYCLES-1.
                    wd_d = wd_q + WD_W'(1);
                    if (wd_q == WD_LIMIT) begin
                        timeout_d = 1'b1;
                        state_d   = S_FAULT;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_FAULT: begin
                if (clear_errors) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            ch_q             <= '0;
            wd_q             <= '0;
            latched_q        <= '0;
            slots_q          <= '0;
            commit_pending_q <= 1'b0;
            ready            <= 1'b1;
            out_samples      <= '0;
            out_valid        <= 1'b0;
            core_tick        <= 1'b0;
            core_channel     <= '0;
            core_sample_in   <= '0;
            core_commit      <= 1'b0;
            overrun          <= 1'b0;
            timeout          <= 1'b0;
            frame_ctr        <= '0;
            overrun_ctr      <= '0;
        end else begin
            state_q          <= state_d;
            ch_q             <= ch_d;
            wd_q             <= wd_d;
            latched_q        <= latched_d;
            slots_q          <= slots_d;
            commit_pending_q <= commit_pending_d;
            ready            <= ready_d;
            out_samples      <= out_samples_d;
            out_valid        <= out_valid_d;
            core_tick        <= core_tick_d;
            core_channel     <= core_channel_d;
            core_sample_in   <= core_sample_in_d;
            core_commit      <= core_commit_d;
            overrun          <= overrun_d;
            timeout          <= timeout_d;
            frame_ctr        <= frame_ctr_d;
            overrun_ctr      <= overrun_ctr_d;
        end
    end

endmodule

// File: tb/tb_dsp_frame_sequencer.sv
// ----------------------------------------------------------------------------
// Testbench for dsp_frame_sequencer: N_CHANNELS=2, TIMEOUT_CYCLES=16, CTR_W=8.
// A mock core returns sample+1 a configurable number of cycles after a tick
// and shows a stale "ready" with junk data in the cycle right after the tick.
// Expected timing, outputs, counters and commits are derived per frame from
// the transaction-level rules (per-channel cost 1+max(2,latency), etc.).
// ----------------------------------------------------------------------------
module tb_dsp_frame_sequencer;

    localparam int DW  = 16;
    localparam int NCH = 2;
    localparam int TO  = 16;
    localparam int CW  = 8;
    localparam int FW  = NCH * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [FW-1:0] in_samples;
    logic          in_valid;
    logic          ready;
    logic [FW-1:0] out_samples;
    logic          out_valid;
    logic          core_tick;
    logic [0:0]    core_channel;
    logic [DW-1:0] core_sample_in;
    logic [DW-1:0] core_sample_out;
    logic          core_ready;
    logic          commit_req;
    logic          core_commit;
    logic          clear_errors;
    logic          overrun;
    logic          timeout;
    logic [CW-1:0] frame_ctr;
    logic [CW-1:0] overrun_ctr;

    dsp_frame_sequencer #(
        .DATA_W(DW), .N_CHANNELS(NCH), .TIMEOUT_CYCLES(TO), .CTR_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .in_samples(in_samples),
        .in_valid(in_valid), .ready(ready), .out_samples(out_samples),
        .out_valid(out_valid), .core_tick(core_tick), .core_channel(core_channel),
        .core_sample_in(core_sample_in), .core_sample_out(core_sample_out),
        .core_ready(core_ready), .commit_req(commit_req), .core_commit(core_commit),
        .clear_errors(clear_errors), .overrun(overrun), .timeout(timeout),
        .frame_ctr(frame_ctr), .overrun_ctr(overrun_ctr)
    );

    always #5 clk = ~clk;

    // Mock core: cnt = cycles since last tick (1 in the cycle after the tick).
    int            cnt      = 0;
    int            core_lat = 2;
    bit            stuck    = 1'b0;
    logic [DW-1:0] res      = '0;

    always @(posedge clk) begin
        if (core_tick) begin
            res <= core_sample_in + DW'(1);
            cnt <= 1;
        end else if (cnt != 0 && cnt < core_lat) begin
            cnt <= cnt + 1;
        end
    end

    assign core_ready      = !stuck && (cnt == 0 || cnt == 1 || cnt >= core_lat);
    assign core_sample_out = (cnt >= core_lat) ? res : 16'hDEAD;

    // Reference state
    int            n_checks = 0;
    int            n_errors = 0;
    logic [CW-1:0] fc       = '0;
    logic [CW-1:0] oc       = '0;
    bit            oflag    = 1'b0;
    logic [FW-1:0] prev_out = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] sat8(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    // Drive one frame in cycle 0 and check every cycle up to L+3, where L is
    // the out_valid cycle. ovr: cycle of an extra (dropped) strobe, -1 none.
    // creq/creq2: cycles carrying commit_req, -1 none.
    task automatic send_frame(input logic [FW-1:0] fr, input bit en, input int lat,
                              input int ovr, input int creq, input int creq2);
        int            per, L, ecommit, nticks;
        bit            exp_tick;
        logic [FW-1:0] exp_out;
        per = 1 + ((lat > 2) ? lat : 2);
        L   = en ? 1 + NCH * per : 1;
        for (int c = 0; c < NCH; c++)
            exp_out[c*DW +: DW] = en ? fr[c*DW +: DW] + DW'(1) : fr[c*DW +: DW];
        if (creq < 0)                ecommit = -1;
        else if (!en)                ecommit = creq + 1;
        else if (creq <= L - 1)      ecommit = L;
        else                         ecommit = L + 2;
        core_lat = lat;
        nticks   = 0;

        step();
        chk("ready_idle", ready, 1'b1);
        in_valid   = 1'b1;
        enable     = en;
        in_samples = fr;
        commit_req = (creq == 0);

        for (int k = 1; k <= L + 3; k++) begin
            step();
            in_valid   = en && (k == ovr);
            commit_req = (k == creq) || (k == creq2);
            enable     = (k <= L) ? 1'($urandom) : en;
            in_samples = $urandom;

            exp_tick = en && (k <= L - 1) && (((k - 1) % per) == 0);
            chk("core_tick", core_tick, exp_tick);
            if (core_tick && nticks < NCH) begin
                chk("core_channel", core_channel, nticks);
                chk("core_sample_in", core_sample_in, fr[nticks*DW +: DW]);
                nticks++;
            end
            chk("out_valid", out_valid, k == L);
            chk("out_samples", out_samples, (k >= L) ? exp_out : prev_out);
            chk("ready", ready, en ? (k > L) : 1'b1);
            chk("core_commit", core_commit, k == ecommit);
            if (k == L) begin
                fc = fc + CW'(1);
                chk("frame_ctr", frame_ctr, fc);
            end
        end
        in_valid   = 1'b0;
        commit_req = 1'b0;
        enable     = 1'b1;

        if (en && ovr >= 1 && ovr <= L) begin
            oflag = 1'b1;
            oc    = sat8(oc);
        end
        chk("tick_count", nticks, en ? NCH : 0);
        chk("overrun", overrun, oflag);
        chk("overrun_ctr", overrun_ctr, oc);
        chk("timeout_idle", timeout, 1'b0);
        prev_out = exp_out;
    endtask

    task automatic clear_flags();
        step();
        clear_errors = 1'b1;
        step();
        clear_errors = 1'b0;
        oflag = 1'b0;
        chk("clr_overrun", overrun, 1'b0);
        chk("clr_timeout", timeout, 1'b0);
        chk("clr_ovr_ctr", overrun_ctr, oc);
        chk("clr_ready", ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset        = 1'b0;
        enable       = 1'b1;
        in_samples   = '0;
        in_valid     = 1'b0;
        commit_req   = 1'b0;
        clear_errors = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_ready", ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_tick", core_tick, 1'b0);
        chk("rst_out_samples", out_samples, '0);
        chk("rst_commit", core_commit, 1'b0);
        chk("rst_frame_ctr", frame_ctr, '0);
        chk("rst_overrun_ctr", overrun_ctr, '0);
        chk("rst_flags", {overrun, timeout}, 2'b00);
        reset = 1'b1;
        step();

        // Nominal two-channel frame
        send_frame(32'h0020_0010, 1'b1, 2, -1, -1, -1);
        chk("nominal_out", out_samples, 32'h0021_0011);
        chk("nominal_fc", frame_ctr, 8'd1);

        // Second strobe at T+3 is dropped; first frame still completes
        send_frame(32'h0040_0030, 1'b1, 2, 3, -1, -1);
        chk("ovr_out", out_samples, 32'h0041_0031);
        chk("ovr_flag", overrun, 1'b1);
        chk("ovr_ctr1", overrun_ctr, 8'd1);
        clear_flags();
        chk("ovr_ctr_kept", overrun_ctr, 8'd1);

        // Bypass
        send_frame(32'hBEEF_1234, 1'b0, 2, -1, -1, -1);
        chk("bypass_out", out_samples, 32'hBEEF_1234);

        // Commit deferral cases
        send_frame($urandom, 1'b1, 2, -1, 0, -1);
        step();
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        chk("idle_commit", core_commit, 1'b1);
        step();
        chk("idle_commit_once", core_commit, 1'b0);
        send_frame($urandom, 1'b1, 3, -1, 2, 5);
        send_frame($urandom, 1'b0, 2, -1, 0, -1);
        send_frame($urandom, 1'b1, 2, -1, 7, -1);

        // Randomised frames
        for (int i = 0; i < 300; i++) begin
            bit            en;
            int            lat, L, ovr, creq;
            logic [FW-1:0] fr;
            en   = ($urandom_range(0, 2) != 0);
            lat  = $urandom_range(2, 5);
            L    = en ? 1 + NCH * (1 + lat) : 1;
            ovr  = (en && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, L)) : -1;
            creq = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, L + 1)) : -1;
            fr   = $urandom;
            send_frame(fr, en, lat, ovr, creq, -1);
            if ($urandom_range(0, 9) == 0) clear_flags();
        end

        // Watchdog: core never ready
        stuck    = 1'b1;
        core_lat = 2;
        step();
        chk("to_ready0", ready, 1'b1);
        in_valid   = 1'b1;
        enable     = 1'b1;
        in_samples = 32'h5555_AAAA;
        for (int k = 1; k <= TO + 1; k++) begin
            step();
            in_valid = 1'b0;
            enable   = 1'($urandom);
            chk("to_tick", core_tick, k == 1);
            chk("to_flag", timeout, k == TO + 1);
            chk("to_ready", ready, 1'b0);
            chk("to_out_valid", out_valid, 1'b0);
        end
        enable = 1'b1;
        for (int j = 0; j < 300; j++) begin
            in_valid   = 1'b1;
            commit_req = (j == 0);
            oc         = sat8(oc);
            step();
            chk("fault_ready", ready, 1'b0);
            chk("fault_tick", core_tick, 1'b0);
            chk("fault_commit", core_commit, 1'b0);
            chk("fault_out_samples", out_samples, prev_out);
        end
        in_valid   = 1'b0;
        commit_req = 1'b0;
        step();
        chk("fault_ovr_sat", overrun_ctr, 8'hFF);
        chk("fault_ovr_model", overrun_ctr, oc);
        chk("fault_flags", {overrun, timeout}, 2'b11);
        clear_errors = 1'b1;
        step();
        clear_errors = 1'b0;
        oflag = 1'b0;
        chk("fault_exit_ready", ready, 1'b1);
        chk("fault_exit_flags", {overrun, timeout}, 2'b00);
        chk("fault_exit_commit0", core_commit, 1'b0);
        step();
        chk("fault_pending_commit", core_commit, 1'b1);
        step();
        chk("fault_commit_once", core_commit, 1'b0);
        chk("fault_ctr_kept", overrun_ctr, 8'hFF);
        chk("fault_fc_kept", frame_ctr, fc);
        stuck = 1'b0;
        send_frame($urandom, 1'b1, 2, -1, -1, -1);

        // Reset while waiting on the core, with a commit pending
        core_lat = 2;
        step();
        in_valid   = 1'b1;
        enable     = 1'b1;
        commit_req = 1'b1;
        in_samples = 32'h7777_6666;
        step();
        in_valid   = 1'b0;
        commit_req = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        fc = '0; oc = '0; oflag = 1'b0; prev_out = '0;
        chk("mid_rst_ready", ready, 1'b1);
        chk("mid_rst_tick", core_tick, 1'b0);
        chk("mid_rst_chan", core_channel, 1'b0);
        chk("mid_rst_smp_in", core_sample_in, '0);
        chk("mid_rst_out", out_samples, '0);
        chk("mid_rst_ctrs", {frame_ctr, overrun_ctr}, 16'h0000);
        chk("mid_rst_flags", {overrun, timeout, out_valid, core_commit}, 4'b0000);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("post_rst_quiet", {out_valid, core_commit, core_tick}, 3'b000);
            chk("post_rst_ready", ready, 1'b1);
        end
        send_frame(32'h0102_0304, 1'b1, 4, -1, -1, -1);
        chk("post_rst_fc", frame_ctr, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
